// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder with a one-entry output register and RV32M multi-cycle tracking.
// Latency: 1 cycle for single-cycle ops; MUL_LAT / DIV_LAT cycles for MUL* / DIV*,REM* ops.
// Backpressure: result held stable until out_ready; a new op may be accepted on the consuming edge.
module alu_ctrl_pipe #(
    parameter int CTRL_W   = 5,
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic              mc_busy,
    output logic              mc_done
);

    // Counter sized so the larger latency minus one always fits without wrapping.
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Instruction formats carried on alu_op.
    localparam logic [2:0] FMT_R = 3'b000;
    localparam logic [2:0] FMT_I = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_S = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_J = 3'b101;
    localparam logic [2:0] FMT_L = 3'b110;

    // ALU operation codes.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SLT  = 5'd1;
    localparam logic [4:0] OP_SLTU = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRA  = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SUB  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BLTU = 5'd13;
    localparam logic [4:0] OP_BGEU = 5'd14;
    localparam logic [4:0] OP_BGE  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  alu_control_q, alu_control_d;
    logic               illegal_q, illegal_d;
    logic               mc_done_q, mc_done_d;

    logic [4:0]         dec_code;
    logic               dec_illegal;
    logic               dec_is_m;
    logic [CNT_W-1:0]   dec_load;
    logic               dec_multi;
    logic               accept;

    // Decode the presented request into an operation code and legality flag.
    always_comb begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
        dec_is_m    = 1'b0;
        case (alu_op)
            FMT_R: begin
                if (funct7_0) begin
                    // M-extension: funct3 indexes MUL..REMU directly.
                    if (!ENABLE_M || funct7_5) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_code = OP_MUL + {2'b00, funct3};
                        dec_is_m = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000: dec_code = funct7_5 ? OP_SUB : OP_ADD;
                        3'b001: dec_code = OP_SLL;
                        3'b010: dec_code = OP_SLT;
                        3'b011: dec_code = OP_SLTU;
                        3'b100: dec_code = OP_XOR;
                        3'b101: dec_code = funct7_5 ? OP_SRA : OP_SRL;
                        3'b110: dec_code = OP_OR;
                        3'b111: dec_code = OP_AND;
                    endcase
                    // Only ADD/SUB and SRL/SRA give funct7_5 a meaning.
                    if (funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            FMT_I: begin
                case (funct3)
                    3'b000: dec_code = OP_ADD;
                    3'b001: dec_code = OP_SLL;
                    3'b010: dec_code = OP_SLT;
                    3'b011: dec_code = OP_SLTU;
                    3'b100: dec_code = OP_XOR;
                    3'b101: dec_code = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110: dec_code = OP_OR;
                    3'b111: dec_code = OP_AND;
                endcase
                // SLLI has no arithmetic variant.
                if ((funct3 == 3'b001) && funct7_5) begin
                    dec_illegal = 1'b1;
                end
            end
            FMT_B: begin
                case (funct3)
                    3'b000:  dec_code = OP_BEQ;
                    3'b001:  dec_code = OP_BNE;
                    3'b100:  dec_code = OP_BLT;
                    3'b101:  dec_code = OP_BGE;
                    3'b110:  dec_code = OP_BLTU;
                    3'b111:  dec_code = OP_BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            FMT_S, FMT_L: begin
                // Only word accesses are supported; address is always an add.
                if (funct3 != 3'b010) begin
                    dec_illegal = 1'b1;
                end
            end
            FMT_U, FMT_J: begin
                dec_code = OP_ADD;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Illegal requests collapse to a harmless single-cycle ADD.
        if (dec_illegal) begin
            dec_code = OP_ADD;
            dec_is_m = 1'b0;
        end
    end

    // Multi-cycle wait length; a latency of one behaves like a single-cycle op.
    always_comb begin
        dec_load  = funct3[2] ? DIV_LOAD : MUL_LOAD;
        dec_multi = dec_is_m && (dec_load != '0);
        accept    = in_valid && in_ready;
    end

    // State register and output/counter flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            alu_control_q <= '0;
            illegal_q     <= 1'b0;
            mc_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_control_q <= alu_control_d;
            illegal_q     <= illegal_d;
            mc_done_q     <= mc_done_d;
        end
    end

    // Next-state: flush wins, then countdown / consume, then a new accept reloads.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_control_d = alu_control_q;
        illegal_d     = illegal_q;
        mc_done_d     = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_MC_WAIT: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d   = ST_HOLD;
                        cnt_d     = '0;
                        mc_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            // Accept only happens in IDLE or on the consuming HOLD edge.
            if (accept) begin
                alu_control_d = CTRL_W'(dec_code);
                illegal_d     = dec_illegal;
                if (dec_multi) begin
                    state_d = ST_MC_WAIT;
                    cnt_d   = dec_load;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
        end
    end

    // Outputs decoded from state; reset and flush block new requests.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mc_busy   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            ST_MC_WAIT: begin
                mc_busy = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        if (reset || flush) begin
            in_ready = 1'b0;
        end
    end

    assign alu_control = alu_control_q;
    assign illegal     = illegal_q;
    assign mc_done     = mc_done_q;

endmodule
